// File: rtl/ctc_pkg.sv
// rtl/ctc_pkg.sv - shared word-time and instruction-field definitions for the bit-serial blocks
package ctc_pkg;

  typedef logic [5:0] word_time_t;

  localparam word_time_t T_CARRY_LAST = 6'd44;
  localparam word_time_t T_IS_FIRST   = 6'd45;
  localparam word_time_t T_IS_LAST    = 6'd54;
  localparam word_time_t T_WORD_END   = 6'd55;

  localparam logic [1:0] ITYPE_TST = 2'b00;
  localparam logic [1:0] ITYPE_JSB = 2'b01;
  localparam logic [1:0] ITYPE_BRN = 2'b11;

  localparam logic [3:0] OP_SEL  = 4'b1100 ^ 4'b1000;
  localparam logic [3:0] OP_DSEL = 4'b1101;

  // Field layout of the 10-bit instruction once shifted in LSB first.
  typedef struct packed {
    logic [2:0] tgt;
    logic       rsvd;
    logic [3:0] op;
    logic [1:0] itype;
  } instr_t;

  function automatic word_time_t next_time(input word_time_t t);
    return (t == T_WORD_END) ? 6'd0 : t + 6'd1;
  endfunction

endpackage

// File: rtl/rom_sel_ctl_if.sv
// rtl/rom_sel_ctl_if.sv - is/sync bus and bank-select outputs of the ROM select controller
interface rom_sel_ctl_if #(
  parameter int NROM = 8,
  parameter int ROMW = 3
);
  logic            sync;
  logic            is;
  logic            carry;
  logic [NROM-1:0] rom_en;
  logic [ROMW-1:0] rom_act;
  logic            dly_pend;
  logic            sync_err;

  modport master (
    output sync, is, carry,
    input  rom_en, rom_act, dly_pend, sync_err
  );

  modport slave (
    input  sync, is, carry,
    output rom_en, rom_act, dly_pend, sync_err
  );
endinterface

// File: rtl/word_timer.sv
// rtl/word_timer.sv - 56-state word-time counter realigned by the rising edge of sync
module word_timer
  import ctc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sync,
  output word_time_t cnt,
  output logic       sync_err
);

  logic sync_q;
  logic sync_rise;

  assign sync_rise = sync & ~sync_q;

  // A misplaced sync edge is treated as T45, so the next state is T46.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      sync_q   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      sync_q <= sync;
      if (sync_rise && (cnt != T_IS_FIRST)) begin
        cnt      <= T_IS_FIRST + 6'd1;
        sync_err <= 1'b1;
      end else begin
        cnt      <= next_time(cnt);
        sync_err <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rom_sel_ctl.sv
// rtl/rom_sel_ctl.sv - decodes serial ROM-select opcodes and drives one-hot ROM enables at word boundaries
module rom_sel_ctl
  import ctc_pkg::*;
#(
  parameter int NROM = 8,
  parameter int ROMW = 3
) (
  input  logic          cph2,
  input  logic          pon,
  rom_sel_ctl_if.slave  bus
);

  word_time_t      cnt;
  logic            sync_err;
  instr_t          ibuf;
  logic            carry_acc;
  logic [ROMW-1:0] rom_act_q;
  logic [ROMW-1:0] dly_tgt;
  logic            dly_pend_q;
  logic [NROM-1:0] rom_en_q;

  logic [ROMW-1:0] act_nxt;
  logic [ROMW-1:0] tgt_nxt;
  logic            pend_nxt;
  logic            tgt_ok;
  logic            in_is_win;

  word_timer u_timer (
    .clk      (cph2),
    .rst      (pon),
    .sync     (bus.sync),
    .cnt      (cnt),
    .sync_err (sync_err)
  );

  assign in_is_win = (cnt >= T_IS_FIRST) && (cnt <= T_IS_LAST);
  assign tgt_ok    = ({1'b0, ibuf.tgt} < 4'(NROM));

  always_comb begin
    act_nxt  = rom_act_q;
    tgt_nxt  = dly_tgt;
    pend_nxt = dly_pend_q;
    if (ibuf.itype == ITYPE_TST && ibuf.op == OP_SEL) begin
      pend_nxt = 1'b0;
      if (tgt_ok) act_nxt = ROMW'(ibuf.tgt);
    end else if (ibuf.itype == ITYPE_TST && ibuf.op == OP_DSEL) begin
      // An out-of-range delayed target disarms rather than arming a bad bank.
      pend_nxt = tgt_ok;
      if (tgt_ok) tgt_nxt = ROMW'(ibuf.tgt);
    end else if (ibuf.itype == ITYPE_JSB && dly_pend_q) begin
      act_nxt  = dly_tgt;
      pend_nxt = 1'b0;
    end else if (ibuf.itype == ITYPE_BRN && dly_pend_q && !carry_acc) begin
      act_nxt  = dly_tgt;
      pend_nxt = 1'b0;
    end
  end

  always_ff @(posedge cph2) begin
    if (pon) begin
      ibuf       <= '0;
      carry_acc  <= 1'b0;
      rom_act_q  <= '0;
      dly_tgt    <= '0;
      dly_pend_q <= 1'b0;
      rom_en_q   <= {{(NROM-1){1'b0}}, 1'b1};
    end else begin
      if (in_is_win) ibuf <= instr_t'({bus.is, ibuf[9:1]});
      if (cnt == T_WORD_END) begin
        rom_act_q  <= act_nxt;
        rom_en_q   <= {{(NROM-1){1'b0}}, 1'b1} << act_nxt;
        dly_tgt    <= tgt_nxt;
        dly_pend_q <= pend_nxt;
        carry_acc  <= 1'b0;
      end else if (cnt <= T_CARRY_LAST) begin
        carry_acc <= carry_acc | bus.carry;
      end
    end
  end

  assign bus.rom_en   = rom_en_q;
  assign bus.rom_act  = rom_act_q;
  assign bus.dly_pend = dly_pend_q;
  assign bus.sync_err = sync_err;

endmodule

// File: tb/tb_rom_sel_ctl.sv
// tb/tb_rom_sel_ctl.sv - directed word-level vectors and corner sequences for rom_sel_ctl
module tb_rom_sel_ctl;

  logic cph2 = 1'b0;
  logic pon;
  int   checks = 0;
  int   errors = 0;

  rom_sel_ctl_if #(.NROM(8), .ROMW(3)) bus ();

  rom_sel_ctl #(.NROM(8), .ROMW(3)) dut (
    .cph2 (cph2),
    .pon  (pon),
    .bus  (bus.slave)
  );

  always #5 cph2 = ~cph2;

  typedef struct {
    logic [9:0] instr;
    int         carry_t;
    logic [2:0] act;
    logic       pend;
  } vec_t;

  vec_t vt[28];

  function automatic logic [9:0] mk(input logic [1:0] ty, input logic [3:0] op, input logic [2:0] tgt);
    return {tgt, 1'b0, op, ty};
  endfunction

  function automatic vec_t vec(input logic [9:0] instr, input int c, input logic [2:0] a, input logic p);
    vec_t v;
    v.instr = instr; v.carry_t = c; v.act = a; v.pend = p;
    return v;
  endfunction

  task automatic tick;
    @(posedge cph2);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_state(input string name, input logic [2:0] act, input logic pend);
    logic [7:0] en;
    en = 8'h01 << act;
    check({name, " rom_act"}, 32'(bus.rom_act), 32'(act));
    check({name, " rom_en"}, 32'(bus.rom_en), 32'(en));
    check({name, " dly_pend"}, 32'(bus.dly_pend), 32'(pend));
    check({name, " sync_err"}, 32'(bus.sync_err), 32'd0);
  endtask

  // Drives one full aligned word from T0; outputs must hold the previous word's state until T55->T0.
  task automatic run_word(input string name, input logic [9:0] instr, input int carry_t,
                          input bit pon_end, input logic [2:0] prev_act, input logic prev_pend);
    logic [7:0] prev_en;
    bit stable;
    stable  = 1'b1;
    prev_en = 8'h01 << prev_act;
    for (int t = 0; t < 56; t++) begin
      bus.sync  = (t >= 45 && t <= 54);
      bus.is    = (t >= 45 && t <= 54) ? instr[t-45] : 1'b0;
      bus.carry = (t == carry_t);
      pon       = pon_end && (t == 55);
      tick;
      if (t < 55) begin
        if (bus.rom_act !== prev_act || bus.rom_en !== prev_en ||
            bus.dly_pend !== prev_pend || bus.sync_err !== 1'b0)
          stable = 1'b0;
      end
    end
    pon = 1'b0;
    check({name, " stable"}, 32'(stable), 32'd1);
  endtask

  initial begin
    logic [9:0] tst, jsb, brn;
    logic [2:0] pa;
    logic       pp;
    int         pulses;

    tst = 10'h000;
    jsb = mk(2'b01, 4'b0000, 3'd0);
    brn = mk(2'b11, 4'b0000, 3'd0);

    vt[0]  = vec(tst, -1, 3'd0, 1'b0);
    vt[1]  = vec(tst, -1, 3'd0, 1'b0);
    vt[2]  = vec(tst, -1, 3'd0, 1'b0);
    vt[3]  = vec(mk(2'b00, 4'b0100, 3'd3), -1, 3'd3, 1'b0);
    vt[4]  = vec(tst, -1, 3'd3, 1'b0);
    vt[5]  = vec(mk(2'b00, 4'b1101, 3'd5), -1, 3'd3, 1'b1);
    vt[6]  = vec(tst, -1, 3'd3, 1'b1);
    vt[7]  = vec(jsb, -1, 3'd5, 1'b0);
    vt[8]  = vec(mk(2'b00, 4'b1101, 3'd6), -1, 3'd5, 1'b1);
    vt[9]  = vec(brn, 12, 3'd5, 1'b1);
    vt[10] = vec(brn, -1, 3'd6, 1'b0);
    vt[11] = vec(mk(2'b00, 4'b1101, 3'd2), -1, 3'd6, 1'b1);
    vt[12] = vec(mk(2'b00, 4'b1101, 3'd4), -1, 3'd6, 1'b1);
    vt[13] = vec(jsb, -1, 3'd4, 1'b0);
    vt[14] = vec(jsb, -1, 3'd4, 1'b0);
    vt[15] = vec(brn, -1, 3'd4, 1'b0);
    vt[16] = vec(mk(2'b00, 4'b0100, 3'd0), -1, 3'd0, 1'b0);
    vt[17] = vec(mk(2'b00, 4'b1101, 3'd7), -1, 3'd0, 1'b1);
    vt[18] = vec(mk(2'b00, 4'b0100, 3'd1), -1, 3'd1, 1'b0);
    vt[19] = vec(mk(2'b00, 4'b1101, 3'd3), -1, 3'd1, 1'b1);
    vt[20] = vec(brn, 44, 3'd1, 1'b1);
    vt[21] = vec(brn, 45, 3'd3, 1'b0);
    vt[22] = vec(mk(2'b00, 4'b1101, 3'd5), -1, 3'd3, 1'b1);
    vt[23] = vec(mk(2'b10, 4'b1101, 3'd2), -1, 3'd3, 1'b1);
    vt[24] = vec(jsb, -1, 3'd5, 1'b0);
    vt[25] = vec(mk(2'b00, 4'b1101, 3'd2), -1, 3'd5, 1'b1);
    vt[26] = vec(brn, 0, 3'd5, 1'b1);
    vt[27] = vec(brn, -1, 3'd2, 1'b0);

    bus.sync = 1'b0; bus.is = 1'b0; bus.carry = 1'b0;
    pon = 1'b1;
    tick;
    check_state("reset", 3'd0, 1'b0);
    pon = 1'b0;

    pa = 3'd0; pp = 1'b0;
    for (int i = 0; i < 28; i++) begin
      run_word($sformatf("word%0d", i), vt[i].instr, vt[i].carry_t, 1'b0, pa, pp);
      check_state($sformatf("word%0d", i), vt[i].act, vt[i].pend);
      pa = vt[i].act; pp = vt[i].pend;
    end

    // Resync: sync rises three clocks early (cnt=42).
    pulses = 0;
    for (int t = 0; t < 42; t++) begin
      bus.sync = 1'b0; bus.is = 1'b0; bus.carry = 1'b0;
      tick;
      if (bus.sync_err === 1'b1) pulses++;
    end
    bus.sync = 1'b1;
    tick;
    check("resync pulse", 32'(bus.sync_err), 32'd1);
    for (int t = 46; t < 56; t++) begin
      bus.sync = (t <= 54);
      tick;
      if (bus.sync_err !== 1'b0) pulses++;
    end
    check("resync extra pulses", 32'(pulses), 32'd0);
    check_state("resync word", 3'd2, 1'b0);
    run_word("post-resync sel6", mk(2'b00, 4'b0100, 3'd6), -1, 1'b0, 3'd2, 1'b0);
    check_state("post-resync sel6", 3'd6, 1'b0);

    // Reset landing on the T55 decode edge discards the pending select.
    run_word("pre-pon dsel3", mk(2'b00, 4'b1101, 3'd3), -1, 1'b0, 3'd6, 1'b0);
    check_state("pre-pon dsel3", 3'd6, 1'b1);
    run_word("pon at t55", mk(2'b00, 4'b0100, 3'd7), -1, 1'b1, 3'd6, 1'b1);
    check_state("pon at t55", 3'd0, 1'b0);
    run_word("after pon", tst, -1, 1'b0, 3'd0, 1'b0);
    check_state("after pon", 3'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_sel_ctl.md
Name: rom_sel_ctl

Overview:
- Bank controller that decides which ROM may drive the shared serial IS line during each instruction fetch.
- Keeps its own 56-state word-time counter, aligned to the system word time by `sync`.
- Captures the serial instruction from IS and decodes the immediate and delayed ROM-select opcodes.
- Drives one-hot ROM enables, which change only on word boundaries. Sits beside the control/timing circuit on the `is`/`sync` bus.

Parameters:
- NROM, 8, number of ROM banks; must be ≤ 8.
- ROMW, 3, width of the bank index; equals clog2(NROM).

Ports:
- cph2  input  1  system clock. All state updates on the rising edge.
- pon  input  1  power-on reset; synchronous, active-high.
- sync  input  1  high during T45–T54 (instruction field on IS).
- is  input  1  serial instruction bit, LSB first, valid while sync=1.
- carry  input  1  arithmetic carry, serial, valid T0–T44.
- rom_en  output  NROM  one-hot enable; the selected ROM may drive IS.
- rom_act  output  ROMW  index of the active bank.
- dly_pend  output  1  a delayed select is armed.
- sync_err  output  1  one-cycle pulse when the counter is realigned.

Behaviour:
- Reset (pon=1 at an edge):
  - cnt=0, rom_act=0, rom_en=1, dly_pend=0, dly_tgt=0.
  - ibuf=0, carry_acc=0, sync_err=0, sync_q=0.
  - Reset has priority over every other event, including mid-decode at T55.
- Counter: cnt runs 0..55 and wraps 55→0.
- Resync:
  - sync_q registers sync.
  - Rising edge = sync=1 & sync_q=0. At a rising edge cnt should already equal 45.
  - If cnt≠45 at a rising edge: load cnt=46 (acts as if this edge were T45) and pulse sync_err for 1 cycle.
  - A rising edge with cnt=45 leaves the counter and sync_err untouched.
- IS capture:
  - While cnt∈[45,54]: ibuf ← {is, ibuf[9:1]}.
  - After T54, ibuf[1:0] = type and ibuf[9:2] = body.
- Carry accumulation:
  - While cnt∈[0,44]: carry_acc ← carry_acc | carry.
  - carry_acc is cleared at the T55 edge, after decode.
- Decode at the cnt=55 edge; all effects become visible at T0 of the next word:
  - SEL (immediate select), type=00 & body[3:0]=4'b0100: rom_act ← body[7:5]. Clears dly_pend.
  - DSEL (delayed select), type=00 & body[3:0]=4'b1101: dly_tgt ← body[7:5], dly_pend ← 1. rom_act unchanged.
  - JSB, type=01, with dly_pend=1: rom_act ← dly_tgt, dly_pend ← 0.
  - BRN, type=11, with dly_pend=1 and carry_acc=0 (branch taken): rom_act ← dly_tgt, dly_pend ← 0.
  - BRN not taken (carry_acc=1): no change; dly_pend stays armed.
  - A second DSEL while dly_pend=1 overwrites dly_tgt (last one wins).
  - Any other instruction: no change.
- Out-of-range target: a select or delayed target ≥ NROM is ignored (rom_act unchanged), but a DSEL still clears dly_pend.
- Enable decode: rom_en = 1<<rom_act, registered. Exactly one bit is high at all times after reset.
- rom_act, rom_en and dly_pend change only on the T55→T0 edge or on reset.
- Fetch latency: an instruction fetched in word N affects the bank for the fetch in word N+1. The bank stays stable for the whole of word N+1, including its T45–T54 fetch window.
- A resync does not clear ibuf. Decode still happens when cnt reaches 55.

Decomposition:
- Shared package ctc_pkg holds:
  - T_IS_FIRST=45, T_IS_LAST=54, T_WORD_END=55, T_CARRY_LAST=44;
  - ITYPE_{TST,JSB,BRN}=2'b00/01/11;
  - OP_SEL=4'b0100, OP_DSEL=4'b1101;
  - the word_time_t 6-bit type.
- One natural sub-module, `word_timer`: the 0..55 counter, the sync edge detector and the resync/sync_err logic. This timer is reused by the other bit-serial blocks.
- Decode and bank registers stay in the top module.

Test Plan:
- Reset then free-run 3 words with `is`=0 → rom_act=0, rom_en=8'h01, dly_pend=0, sync_err never pulses.
- SEL with body=8'b011_0100 (target 3) in word 1 → rom_en=8'h08 from T0 of word 2, held for all 56 cycles.
- DSEL target 5, then TST, then JSB → dly_pend=1 after word 1; rom_act=0 through word 2; rom_act=5 and dly_pend=0 at T0 of word 4.
- DSEL target 6, then BRN with carry=1 at T12 → no switch and dly_pend stays 1; next BRN with carry all 0 → rom_act=6.
- Drop 3 clocks of sync phase (first sync rise at cnt=42) → sync_err pulses once; cnt=46 on the next cycle; the following SEL still decodes correctly.
- Assert pon at cnt=55 with a valid SEL 7 in ibuf → rom_act=0 and rom_en=8'h01; the select is discarded.
